// File: rtl/keycode_direction.sv
// keycode_direction: turns raw HID keycodes into single-cycle maze direction pulses and hangman letter strobes
module keycode_direction #(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       game_mode,
  output logic [3:0] direction,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       key_held
);
  localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE - 1);
  typedef enum logic [1:0] {IDLE, FIRE, HOLD, LOCK} state_t;
  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic [7:0]    r_kc, r_held_kc, r_letter, w_letter;
  logic          r_mode, r_held_mode, r_letter_valid, w_letter_valid;
  logic [3:0]    r_direction, w_dir_map, w_direction;
  logic          w_is_letter, w_mapped, w_repeat, w_fire;

  // Register the raw inputs once; every decision below works from these copies
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_kc   <= 8'h00;
      r_mode <= 1'b0;
    end else begin
      r_kc   <= keycode;
      r_mode <= game_mode;
    end

  // Decode the registered keycode against the maze and hangman key maps
  always_comb begin
    w_dir_map   = (r_kc == 8'h1A || r_kc == 8'h52) ? 4'b0001 :
                  (r_kc == 8'h16 || r_kc == 8'h51) ? 4'b0010 :
                  (r_kc == 8'h04 || r_kc == 8'h50) ? 4'b0100 :
                  (r_kc == 8'h07 || r_kc == 8'h4F) ? 4'b1000 : 4'b0000;
    w_is_letter = (r_kc >= 8'h04) && (r_kc <= 8'h1D);
    w_mapped    = r_mode ? w_is_letter : |w_dir_map;
  end

  // Next state, repeat counter and the event that the output register will present
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_repeat     = 1'b0;
    case (r_state)
      IDLE: w_next_state = w_mapped ? FIRE : IDLE;
      FIRE: begin
        w_next_state = (r_mode != r_held_mode) ? LOCK : HOLD;
        w_next_cnt   = DELAY_LD;
      end
      HOLD:
        if (r_mode != r_held_mode) w_next_state = LOCK;
        else if (r_kc == 8'h00) w_next_state = IDLE;
        else if (r_kc != r_held_kc) w_next_state = w_mapped ? FIRE : LOCK;
        else if (!r_mode) begin
          w_repeat   = (r_cnt == '0);
          w_next_cnt = w_repeat ? RATE_LD : r_cnt - CW'(1);
        end
      LOCK: w_next_state = (r_kc == 8'h00) ? IDLE : LOCK;
      default: w_next_state = IDLE;
    endcase
    w_fire         = (w_next_state == FIRE);
    w_direction    = ((w_fire && !r_mode) || w_repeat) ? w_dir_map : 4'b0000;
    w_letter_valid = w_fire && r_mode;
    w_letter       = w_letter_valid ? r_kc + 8'h5D : 8'h00;
  end

  // State and counter; the accepted key and mode are latched on entry to FIRE
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_held_kc   <= 8'h00;
      r_held_mode <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_fire) begin
        r_held_kc   <= r_kc;
        r_held_mode <= r_mode;
      end
    end

  // Event outputs are registered so each pulse coincides with the FIRE or repeat cycle
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_direction    <= 4'b0000;
      r_letter_valid <= 1'b0;
      r_letter       <= 8'h00;
    end else begin
      r_direction    <= w_direction;
      r_letter_valid <= w_letter_valid;
      r_letter       <= w_letter;
    end

  assign direction    = r_direction;
  assign letter_valid = r_letter_valid;
  assign letter       = r_letter;
  assign key_held     = (r_state == FIRE) || (r_state == HOLD);
endmodule

// File: tb/tb_keycode_direction.sv
// tb_keycode_direction: table vectors, corner sequences and a random run against a timing-rule model
module tb_keycode_direction;
  localparam int D = 8;
  localparam int R = 4;
  logic       Clk = 1'b0, Reset = 1'b0, game_mode = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [3:0] direction;
  logic [7:0] letter;
  logic       letter_valid, key_held;
  int n_chk = 0, n_fail = 0;

  keycode_direction #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .game_mode(game_mode),
    .direction(direction), .letter(letter), .letter_valid(letter_valid), .key_held(key_held)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] kc;
    logic       md;
    logic [3:0] dir;
    logic       lv;
    logic [7:0] ltr;
    logic       held;
  } vec_t;
  vec_t tbl [256];
  int   tn = 0;

  function automatic void add(input logic [7:0] kc, input logic md, input int n);
    for (int i = 0; i < n; i++) begin
      tbl[tn] = '{kc: kc, md: md, dir: 4'b0000, lv: 1'b0, ltr: 8'h00, held: 1'b0};
      tn++;
    end
  endfunction

  function automatic void set_held(input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].held = 1'b1;
  endfunction

  function automatic void set_dir(input int i, input logic [3:0] d);
    tbl[i].dir = d;
  endfunction

  function automatic void set_ltr(input int i, input logic [7:0] l);
    tbl[i].lv  = 1'b1;
    tbl[i].ltr = l;
  endfunction

  function automatic logic [31:0] outs();
    return {18'b0, direction, letter_valid, letter, key_held};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [7:0] kc, input logic md);
    keycode   = kc;
    game_mode = md;
    @(posedge Clk);
    #1;
  endtask

  // Reference model: press/hold semantics with repeat times derived from the fire edge number
  logic [7:0] m_rk, m_hk, m_let;
  logic       m_rm, m_hm, m_holding, m_locked, m_lv;
  logic [3:0] m_dir;
  int         m_n, m_tfire;

  function automatic logic [3:0] dmap(input logic [7:0] k);
    case (k)
      8'h1A, 8'h52: return 4'b0001;
      8'h16, 8'h51: return 4'b0010;
      8'h04, 8'h50: return 4'b0100;
      8'h07, 8'h4F: return 4'b1000;
      default:      return 4'b0000;
    endcase
  endfunction

  function automatic logic mapped(input logic [7:0] k, input logic md);
    return md ? (k >= 8'h04 && k <= 8'h1D) : (dmap(k) != 4'b0000);
  endfunction

  task automatic model_reset();
    m_rk = 8'h00; m_hk = 8'h00; m_let = 8'h00; m_rm = 1'b0; m_hm = 1'b0;
    m_holding = 1'b0; m_locked = 1'b0; m_lv = 1'b0; m_dir = 4'b0000;
    m_n = 0; m_tfire = -100;
  endtask

  task automatic model_edge();
    logic fire, rep;
    int k;
    fire = 1'b0;
    rep  = 1'b0;
    m_n++;
    if (m_holding) begin
      if (m_rm != m_hm) begin
        m_holding = 1'b0;
        m_locked  = 1'b1;
      end else if (m_n == m_tfire + 1) begin
        m_holding = 1'b1;
      end else if (m_rk == 8'h00) begin
        m_holding = 1'b0;
      end else if (m_rk != m_hk) begin
        if (mapped(m_rk, m_rm)) fire = 1'b1;
        else begin
          m_holding = 1'b0;
          m_locked  = 1'b1;
        end
      end else if (!m_hm) begin
        k   = m_n - m_tfire;
        rep = (k >= D + 1) && ((k - D - 1) % R == 0);
      end
    end else if (m_locked) begin
      if (m_rk == 8'h00) m_locked = 1'b0;
    end else if (mapped(m_rk, m_rm)) begin
      fire = 1'b1;
    end
    if (fire) begin
      m_holding = 1'b1;
      m_hk      = m_rk;
      m_hm      = m_rm;
      m_tfire   = m_n;
    end
    m_dir = ((fire && !m_rm) || rep) ? dmap(m_rk) : 4'b0000;
    m_lv  = fire && m_rm;
    m_let = m_lv ? m_rk + 8'h5D : 8'h00;
  endtask

  logic [7:0] pool [16] = '{8'h00, 8'h00, 8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04,
                            8'h50, 8'h07, 8'h4F, 8'h10, 8'h1D, 8'h1E, 8'h33, 8'h03};

  initial begin
    int b, hold;
    logic [7:0] kd;
    logic md;
    // Reset: outputs stay 0 even with a mapped key driven
    tick(8'h1A, 1'b0);
    chk("reset_outs", outs(), 32'h0);
    tick(8'h00, 1'b0);
    chk("reset_outs2", outs(), 32'h0);
    Reset = 1'b1;

    // Vector table built from the expected event times
    add(8'h00, 1'b0, 3);
    b = tn; add(8'h1A, 1'b0, 5); add(8'h00, 1'b0, 5);
    set_dir(b + 2, 4'b0001); set_held(b + 2, b + 6);
    b = tn; add(8'h07, 1'b0, 30); add(8'h00, 1'b0, 8);
    foreach (tbl[i]) if (i == b + 2 || i == b + 11 || i == b + 15 || i == b + 19 ||
                         i == b + 23 || i == b + 27 || i == b + 31) set_dir(i, 4'b1000);
    set_held(b + 2, b + 31);
    b = tn; add(8'h04, 1'b1, 30); add(8'h00, 1'b1, 6);
    set_ltr(b + 2, 8'h61); set_held(b + 2, b + 31);
    add(8'h00, 1'b0, 2);
    b = tn; add(8'h04, 1'b0, 6); add(8'h07, 1'b0, 13); add(8'h00, 1'b0, 6);
    set_dir(b + 2, 4'b0100); set_dir(b + 8, 4'b1000); set_dir(b + 17, 4'b1000);
    set_held(b + 2, b + 20);
    b = tn; add(8'h16, 1'b0, 5); add(8'h16, 1'b1, 7); add(8'h00, 1'b1, 5);
    add(8'h16, 1'b1, 5); add(8'h00, 1'b1, 5);
    set_dir(b + 2, 4'b0010); set_held(b + 2, b + 6);
    set_ltr(b + 19, 8'h73); set_held(b + 19, b + 23);
    add(8'h00, 1'b0, 3);
    for (int i = 0; i < tn; i++) begin
      chk($sformatf("vec[%0d]", i), outs(),
          {18'b0, tbl[i].dir, tbl[i].lv, tbl[i].ltr, tbl[i].held});
      tick(tbl[i].kc, tbl[i].md);
    end

    // Glitch to an unmapped code while holding locks out all events until release
    tick(8'h07, 1'b0); tick(8'h07, 1'b0);
    chk("glitch_fire", {28'b0, direction}, 32'h8);
    tick(8'h33, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick(8'h07, 1'b0);
      chk($sformatf("glitch_quiet[%0d]", i), {28'b0, direction}, 32'h0);
    end
    chk("glitch_lock_held", {31'b0, key_held}, 32'h0);
    tick(8'h00, 1'b0); tick(8'h00, 1'b0); tick(8'h00, 1'b0);
    tick(8'h07, 1'b0); tick(8'h07, 1'b0);
    chk("glitch_refire", {28'b0, direction}, 32'h8);
    tick(8'h00, 1'b0); tick(8'h00, 1'b0); tick(8'h00, 1'b0);

    // Reset asserted mid-hold clears everything at once; still-held key fires again afterwards
    tick(8'h51, 1'b0); tick(8'h51, 1'b0);
    chk("rst_first_fire", {28'b0, direction}, 32'h2);
    repeat (8) tick(8'h51, 1'b0);
    chk("rst_pre_held", {31'b0, key_held}, 32'h1);
    Reset = 1'b0;
    #1;
    chk("rst_async", outs(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(8'h51, 1'b0);
      chk($sformatf("rst_during[%0d]", i), outs(), 32'h0);
    end
    Reset = 1'b1;
    tick(8'h51, 1'b0);
    chk("rst_after1", outs(), 32'h0);
    tick(8'h51, 1'b0);
    chk("rst_after2", outs(), {18'b0, 4'b0010, 1'b0, 8'h00, 1'b1});
    tick(8'h00, 1'b0); tick(8'h00, 1'b0); tick(8'h00, 1'b0);
    chk("rst_release", {31'b0, key_held}, 32'h0);

    // Random run against the model
    Reset = 1'b0;
    tick(8'h00, 1'b0);
    Reset = 1'b1;
    model_reset();
    hold = 0;
    kd = 8'h00;
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk($sformatf("rand[%0d]", c), outs(), {18'b0, m_dir, m_lv, m_let, m_holding});
      if (hold == 0) begin
        kd   = pool[$urandom_range(0, 15)];
        hold = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 12);
        if ($urandom_range(0, 5) == 0) md = ~md;
      end else if ($urandom_range(0, 39) == 0) begin
        md = ~md;
      end
      hold--;
      tick(kd, md);
      model_edge();
      m_rk = kd;
      m_rm = md;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
